// File: rtl/noc_params.sv
// Shared NoC types: mesh size, VC count, flit and port encodings.
// flit_t carries label, VC id and the XY destination of a head flit.
package noc_params;

  localparam int MESH_SIZE_X = 4;
  localparam int MESH_SIZE_Y = 4;
  localparam int VC_NUM = 2;

  localparam int DEST_ADDR_SIZE_X = $clog2(MESH_SIZE_X);
  localparam int DEST_ADDR_SIZE_Y = $clog2(MESH_SIZE_Y);
  localparam int VC_SIZE = $clog2(VC_NUM);
  localparam int HEAD_PAYLOAD_SIZE = 12;

  typedef enum logic [1:0] {
    HEAD,
    BODY,
    TAIL,
    HEADTAIL
  } flit_label_t;

  typedef enum logic [2:0] {
    LOCAL,
    NORTH,
    SOUTH,
    WEST,
    EAST
  } port_t;

  typedef struct packed {
    logic [DEST_ADDR_SIZE_X-1:0] x_dest;
    logic [DEST_ADDR_SIZE_Y-1:0] y_dest;
    logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
  } head_data_t;

  typedef struct packed {
    flit_label_t flit_label;
    logic [VC_SIZE-1:0] vc_id;
    head_data_t head_data;
  } flit_t;

  localparam int PORT_WIDTH = $bits(flit_t);

endpackage

// File: rtl/input_port_unit.sv
// Router input port: per-VC flit FIFOs, XY routing of head flits,
// per-VC IDLE/ROUTED FSM, registered credit and error pulses.
// Ports: clk, rst (async high); data_i/valid_flit_i in; read_i per-VC pop;
// data_o/is_valid_o/out_port_o per-VC front; credit_o per VC; error_o.
module input_port_unit
  import noc_params::*;
#(
  parameter int BUFFER_SIZE = 8,
  parameter int X_CURRENT = 0,
  parameter int Y_CURRENT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  flit_t             data_i,
  input  logic              valid_flit_i,
  input  logic [VC_NUM-1:0] read_i,
  output flit_t             data_o [VC_NUM],
  output logic [VC_NUM-1:0] is_valid_o,
  output port_t             out_port_o [VC_NUM],
  output logic [VC_NUM-1:0] credit_o,
  output logic              error_o
);

  localparam int AW = $clog2(BUFFER_SIZE);
  localparam logic [DEST_ADDR_SIZE_X-1:0] XC =
    DEST_ADDR_SIZE_X'(X_CURRENT);
  localparam logic [DEST_ADDR_SIZE_Y-1:0] YC =
    DEST_ADDR_SIZE_Y'(Y_CURRENT);

  typedef enum logic {
    IDLE,
    ROUTED
  } vc_state_t;

  flit_t             mem [VC_NUM][BUFFER_SIZE];
  logic [AW:0]       wr_ptr [VC_NUM];
  logic [AW:0]       rd_ptr [VC_NUM];
  vc_state_t         state [VC_NUM];
  vc_state_t         state_nxt [VC_NUM];
  port_t             route [VC_NUM];
  logic [VC_NUM-1:0] empty;
  logic [VC_NUM-1:0] full;
  logic [VC_NUM-1:0] pop;
  logic [VC_NUM-1:0] route_en;
  logic [VC_NUM-1:0] proto_err;
  logic [VC_NUM-1:0] push;
  logic              overflow;

  function automatic port_t xy_route(head_data_t h);
    port_t p;
    p = LOCAL;
    if (h.x_dest > XC)      p = EAST;
    else if (h.x_dest < XC) p = WEST;
    else if (h.y_dest > YC) p = SOUTH;
    else if (h.y_dest < YC) p = NORTH;
    return p;
  endfunction

  always_comb begin
    for (int v = 0; v < VC_NUM; v++) begin
      empty[v] = (wr_ptr[v] == rd_ptr[v]);
      full[v] = (wr_ptr[v][AW] != rd_ptr[v][AW]) &&
                (wr_ptr[v][AW-1:0] == rd_ptr[v][AW-1:0]);
      data_o[v] = mem[v][rd_ptr[v][AW-1:0]];
      route[v] = xy_route(data_o[v].head_data);
      is_valid_o[v] = (state[v] == ROUTED) && !empty[v];
      state_nxt[v] = state[v];
      pop[v] = 1'b0;
      route_en[v] = 1'b0;
      proto_err[v] = 1'b0;
      unique case (state[v])
        IDLE: begin
          if (!empty[v]) begin
            if (data_o[v].flit_label == HEAD ||
                data_o[v].flit_label == HEADTAIL) begin
              route_en[v] = 1'b1;
              state_nxt[v] = ROUTED;
            end else begin
              // stray body/tail: drop it so the VC cannot lock up
              pop[v] = 1'b1;
              proto_err[v] = 1'b1;
            end
          end
        end
        ROUTED: begin
          if (read_i[v] && is_valid_o[v]) begin
            pop[v] = 1'b1;
            if (data_o[v].flit_label == TAIL ||
                data_o[v].flit_label == HEADTAIL)
              state_nxt[v] = IDLE;
          end
        end
        default: state_nxt[v] = IDLE;
      endcase
    end
  end

  // a full VC still accepts when it pops in the same cycle
  always_comb begin
    push = '0;
    overflow = 1'b0;
    if (valid_flit_i) begin
      if (!full[data_i.vc_id] || pop[data_i.vc_id])
        push[data_i.vc_id] = 1'b1;
      else
        overflow = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int v = 0; v < VC_NUM; v++)
      if (push[v])
        mem[v][wr_ptr[v][AW-1:0]] <= data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < VC_NUM; v++) begin
        wr_ptr[v] <= '0;
        rd_ptr[v] <= '0;
        state[v] <= IDLE;
        out_port_o[v] <= LOCAL;
      end
      credit_o <= '0;
      error_o <= 1'b0;
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (push[v]) wr_ptr[v] <= wr_ptr[v] + 1'b1;
        if (pop[v]) rd_ptr[v] <= rd_ptr[v] + 1'b1;
        if (route_en[v]) out_port_o[v] <= route[v];
        state[v] <= state_nxt[v];
      end
      credit_o <= pop;
      error_o <= overflow || (|proto_err);
    end
  end

endmodule

// File: doc/input_port_unit.md
Name: input_port_unit

Overview:
- Router input stage fed directly by the upstream link: accepts one flit_t per cycle and stores it in the per-VC FIFO selected by the flit's vc_id.
- Performs XY route computation on each packet's head flit and presents the routed flit at the front of each VC to the downstream VC/switch allocation stage.
- Returns per-VC credits to the upstream router.
- Uses noc_params types: flit_t, port_t, VC_NUM, MESH_SIZE_X/Y.

Parameters:
- BUFFER_SIZE, 8, flit depth of each per-VC FIFO (power of two, >= 2).
- X_CURRENT, 0, x coordinate of this router (0..MESH_SIZE_X-1).
- Y_CURRENT, 0, y coordinate of this router (0..MESH_SIZE_Y-1).

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- data_i  input  flit_t (PORT_WIDTH)  incoming flit.
- valid_flit_i  input  1  data_i valid this cycle.
- read_i  input  [VC_NUM-1:0]  pop front flit of VC v.
- data_o  output  flit_t [VC_NUM]  front flit of each VC.
- is_valid_o  output  [VC_NUM-1:0]  VC v front flit routed and readable.
- out_port_o  output  port_t [VC_NUM]  route of the packet at VC v front.
- credit_o  output  [VC_NUM-1:0]  one-cycle credit pulse to upstream, per VC.
- error_o  output  1  one-cycle pulse on overflow or label-sequence error.

Behaviour:
- Reset: all FIFOs empty, pointers 0, VC states IDLE; is_valid_o=0, out_port_o=LOCAL, credit_o=0, error_o=0. data_o is don't-care while is_valid_o=0.
- Reset mid-packet discards all buffered flits. Upstream must reload its credit counters to BUFFER_SIZE.
- Write: on valid_flit_i, data_i is pushed into FIFO[data_i.vc_id].
  - FIFO full and no same-cycle pop on that VC: flit dropped, error_o pulses next cycle.
  - Full with a same-cycle pop on that VC: write accepted.
- Route computation (XY), from head_data of the front flit:
  - x_dest>X_CURRENT -> EAST; x_dest<X_CURRENT -> WEST.
  - Otherwise y_dest>Y_CURRENT -> SOUTH; y_dest<Y_CURRENT -> NORTH.
  - Otherwise LOCAL.
- Per-VC FSM, states IDLE and ROUTED:
  - IDLE, front is HEAD or HEADTAIL: register the computed route into out_port_o[v] and go to ROUTED. No pop.
  - IDLE, front is BODY or TAIL: protocol error. Flit is auto-popped (discarded), credit returned, error_o pulses next cycle, state stays IDLE.
  - ROUTED: is_valid_o[v] = FIFO non-empty.
    - read_i[v] with is_valid_o[v] pops the front.
    - Popping TAIL or HEADTAIL returns to IDLE; out_port_o[v] holds its last value.
    - Popping HEAD or BODY stays in ROUTED.
  - A HEAD/HEADTAIL reaching the front while ROUTED is forwarded as part of the current packet. No check is made; upstream guarantees packet order per VC.
- read_i[v] while is_valid_o[v]=0 is ignored.
- Latency: flit sampled on edge t into an empty VC is at the front after t. If it is a head, the route is latched at t+1, so is_valid_o is high in the cycle after edge t+1. Minimum 2 cycles input-to-valid. Body flits behind a routed head are valid 1 cycle after write.
- Throughput: one pop per VC per cycle and one push per cycle in total. Simultaneous push and pop on the same VC is supported at every occupancy.
- Credits: credit_o[v] pulses exactly one cycle after each pop of VC v (registered). Applies to both normal reads and error discards.
- Pointers: log2(BUFFER_SIZE) bits plus one wrap bit. Full and empty are decided by the wrap bit.

Test Plan:
- Router (1,2), VC0 HEADTAIL x_dest=3,y_dest=0 into empty buffer -> is_valid_o[0]=1 two cycles later, out_port_o[0]=EAST. read_i[0] pops it -> credit_o[0] pulses one cycle later, VC0 returns to IDLE.
- Router (1,2), VC1 HEAD(x=1,y=2), BODY, BODY, TAIL back-to-back, read_i[1] held high -> out_port_o[1]=LOCAL, 4 flits delivered in order, 4 credit pulses, then IDLE.
- Interleaved: VC0 HEAD(x=0) and VC1 HEAD(x=1,y=3) on alternating cycles -> out_port_o[0]=WEST, out_port_o[1]=SOUTH, no cross-VC corruption.
- BUFFER_SIZE=8: 9 flits to VC0 with no reads -> first 8 stored, 9th dropped, error_o pulses once. Next cycle push plus read while full -> accepted, occupancy stays 8.
- BODY arriving on an IDLE VC -> discarded, error_o=1 and credit_o pulse, is_valid_o stays 0.
- Assert rst with 5 flits buffered mid-packet -> all outputs 0 immediately; after release, a new HEAD routes normally.
